// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer: owns the PC, addresses the combinational instruction ROM
// and queues {pc, instruction} pairs toward decode with a valid/ready handshake.
// Supports redirect (flush + new PC), back-pressure stalls and a sticky halt.
module inst_fetch_ctrl #(
  parameter int              AW       = 6,
  parameter int              DW       = 32,
  parameter int              QDEPTH   = 2,
  parameter logic [AW-1:0]   RESET_PC = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          halt,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_inst,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [DW-1:0] inst_out,
  output logic [AW-1:0] inst_pc,
  output logic [1:0]    state,
  output logic [15:0]   fetch_cnt
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [PW:0] QFULL = (PW+1)'(QDEPTH);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_HALT = 2'b10;

  logic [AW-1:0] pc;
  logic [DW-1:0] q_inst [QDEPTH];
  logic [AW-1:0] q_pc   [QDEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic          pop;
  logic          push;
  logic          flush;

  assign pop   = inst_valid & inst_ready;
  assign flush = redirect & (state != S_HALT);
  assign push  = (state == S_RUN) & en & ~halt & ~redirect & ((count < QFULL) | pop);

  assign rom_addr   = pc;
  assign inst_valid = (count != '0);
  assign inst_out   = q_inst[rd_ptr];
  assign inst_pc    = q_pc[rd_ptr];

  // Control FSM: halt dominates en and is only left through reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (halt) state <= S_HALT; else if (en)  state <= S_RUN;
        S_RUN:   if (halt) state <= S_HALT; else if (!en) state <= S_IDLE;
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Program counter: redirect target wins, otherwise advance on every push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (flush) begin
      pc <= redirect_pc;
    end else if (push) begin
      pc <= pc + AW'(1);
    end
  end

  // Fetch queue: a flush drops every entry, including one popped this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        q_inst[i] <= '0;
        q_pc[i]   <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        q_inst[wr_ptr] <= rom_inst;
        q_pc[wr_ptr]   <= pc;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Saturating push counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
    end else if (push && (fetch_cnt != '1)) begin
      fetch_cnt <= fetch_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Testbench for inst_fetch_ctrl: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based behavioural model.
module tb_inst_fetch_ctrl;

  localparam int QD = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        halt;
  logic        redirect;
  logic [5:0]  redirect_pc;
  logic [5:0]  rom_addr;
  logic [31:0] rom_inst;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [5:0]  inst_pc;
  logic [1:0]  state;
  logic [15:0] fetch_cnt;

  logic [31:0] rom [64];
  assign rom_inst = rom[rom_addr];

  always #5 clk = ~clk;

  inst_fetch_ctrl #(.AW(6), .DW(32), .QDEPTH(QD), .RESET_PC(6'h01)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .halt(halt), .redirect(redirect),
    .redirect_pc(redirect_pc), .rom_addr(rom_addr), .rom_inst(rom_inst),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_out(inst_out),
    .inst_pc(inst_pc), .state(state), .fetch_cnt(fetch_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: queue of fetched words, pc, mode (0 idle, 1 run, 2 halt).
  typedef struct { int pc; logic [31:0] w; } ent_t;
  ent_t mq[$];
  int   m_pc;
  int   m_mode;
  int   m_cnt;

  task automatic m_reset();
    mq.delete();
    m_pc   = 1;
    m_mode = 0;
    m_cnt  = 0;
  endtask

  task automatic m_edge();
    bit   pop_now;
    bit   push_now;
    int   nxt;
    ent_t e;
    pop_now  = (mq.size() > 0) && inst_ready;
    push_now = (m_mode == 1) && en && !halt && !redirect && ((mq.size() < QD) || pop_now);
    if (m_mode == 2)   nxt = 2;
    else if (halt)     nxt = 2;
    else               nxt = en ? 1 : 0;
    if (m_mode != 2 && redirect) begin
      mq.delete();
      m_pc = int'(redirect_pc);
    end else begin
      if (pop_now) void'(mq.pop_front());
      if (push_now) begin
        e.pc = m_pc;
        e.w  = rom[m_pc];
        mq.push_back(e);
        m_pc = (m_pc + 1) % 64;
        if (m_cnt < 65535) m_cnt++;
      end
    end
    m_mode = nxt;
  endtask

  task automatic check_all();
    check("rom_addr", 32'(rom_addr), 32'(m_pc));
    check("inst_valid", 32'(inst_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      check("inst_out", inst_out, mq[0].w);
      check("inst_pc", 32'(inst_pc), 32'(mq[0].pc));
    end
    check("state", 32'(state), 32'(m_mode));
    check("fetch_cnt", 32'(fetch_cnt), 32'(m_cnt));
  endtask

  task automatic drive(input bit e, input bit h, input bit r, input logic [5:0] rp, input bit rdy);
    en = e; halt = h; redirect = r; redirect_pc = rp; inst_ready = rdy;
  endtask

  task automatic step();
    m_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Asynchronous reset asserted between edges, held across one edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    check_all();
    check("rst_inst_out", inst_out, 32'h0);
    check("rst_inst_pc", 32'(inst_pc), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int saved_cnt;

  initial begin
    rom[0]  = 32'h0;
    for (int i = 1; i < 64; i++) rom[i] = $urandom;
    rom[1]  = 32'h00101464;
    rom[10] = 32'h04100841;

    rst_n = 1'b0;
    drive(0, 0, 0, 6'h0, 0);
    m_reset();
    @(posedge clk);
    #1;
    do_reset();

    // T1: stream from reset
    drive(1, 0, 0, 6'h0, 1);
    check("t1_addr0", 32'(rom_addr), 32'h01);
    step();
    step();
    check("t1_valid", 32'(inst_valid), 32'h1);
    check("t1_pc", 32'(inst_pc), 32'h01);
    check("t1_inst", inst_out, 32'h00101464);
    for (int i = 0; i < 6; i++) step();

    // T2: back-pressure from reset
    do_reset();
    drive(1, 0, 0, 6'h0, 0);
    for (int i = 0; i < 6; i++) step();
    check("t2_stall_addr", 32'(rom_addr), 32'h03);
    check("t2_cnt", 32'(fetch_cnt), 32'd2);
    inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // T3: redirect while full
    inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) step();
    drive(1, 0, 1, 6'h0A, 0);
    step();
    check("t3_valid", 32'(inst_valid), 32'h0);
    check("t3_addr", 32'(rom_addr), 32'h0A);
    drive(1, 0, 0, 6'h0, 0);
    step();
    check("t3_pc", 32'(inst_pc), 32'h0A);
    check("t3_inst", inst_out, 32'h04100841);

    // T4: pc wrap
    drive(1, 0, 1, 6'h3F, 1);
    step();
    drive(1, 0, 0, 6'h0, 1);
    step();
    check("t4_addr", 32'(rom_addr), 32'h00);
    step();
    check("t4_pc", 32'(inst_pc), 32'h00);
    check("t4_inst", inst_out, 32'h0);

    // T5: halt with two entries queued
    inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) step();
    drive(1, 1, 0, 6'h0, 0);
    step();
    check("t5_state", 32'(state), 32'h2);
    saved_cnt = int'(fetch_cnt);
    for (int i = 0; i < 8; i++) begin
      drive(i[0], 0, i[1], 6'h15, i >= 3);
      step();
    end
    check("t5_drained", 32'(inst_valid), 32'h0);
    check("t5_cnt_frozen", 32'(fetch_cnt), 32'(saved_cnt));

    // T6: reset mid-stream, then T1 repeats
    do_reset();
    drive(1, 0, 0, 6'h0, 1);
    for (int i = 0; i < 4; i++) step();
    do_reset();
    drive(1, 0, 0, 6'h0, 1);
    step();
    step();
    check("t6_pc", 32'(inst_pc), 32'h01);
    check("t6_inst", inst_out, 32'h00101464);

    // Randomized traffic
    for (int blk = 0; blk < 20; blk++) begin
      do_reset();
      for (int c = 0; c < 100; c++) begin
        drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 99) == 0),
              ($urandom_range(0, 19) == 0), 6'($urandom_range(0, 63)),
              ($urandom_range(0, 9) < 6));
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
